// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;
  typedef enum logic [1:0] {HIT, NONE, GHOST} sclass_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] key_code(input logic [1:0] ridx, input logic [1:0] cidx);
    return {ridx, cidx};
  endfunction

endpackage

// File: rtl/keypad_scan_sync.sv
// Multi-bit two-flop synchronizer; resets to RSTVAL so idle pulled-up lines read inactive.
module keypad_scan_sync #(
  parameter int                 NUMBITS = 4,
  parameter logic [NUMBITS-1:0] RSTVAL  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] d,
  output logic [NUMBITS-1:0] q
);
  logic [NUMBITS-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RSTVAL;
      q    <= RSTVAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one column driven low per dwell period, rows sampled at the end
// of the dwell, debounced and ghost-rejected into a one-cycle key event.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int CLKSPDMHZ = 100,
  parameter int DWELLUS   = 1000,
  parameter int DBCOUNT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyDown
);
  localparam int DWELL = CLKSPDMHZ * DWELLUS;
  localparam int CW    = $clog2(DWELL);
  localparam int MW    = $clog2(DBCOUNT + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [MW-1:0] DB_LAST    = MW'(DBCOUNT - 1);

  logic [3:0]    rows_s;
  logic [CW-1:0] cnt;
  logic          sample;
  state_t        state, state_n;
  logic [MW-1:0] match, match_n;
  logic [1:0]    cand_row, cand_row_n, cand_col, cand_col_n;
  logic [3:0]    col_n, code_n;
  logic          valid_n, down_n, accept;
  logic [2:0]    zeros;
  logic [1:0]    ridx, cidx;
  sclass_t       cls;

  keypad_scan_sync #(.NUMBITS(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (rows_s)
  );

  assign sample = (cnt == DWELL_LAST);

  // Row classification: exactly one low row is a hit, several low rows is a ghost.
  always_comb begin
    zeros = '0;
    ridx  = '0;
    cidx  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rows_s[i]) begin
        zeros = zeros + 3'd1;
        ridx  = 2'(i);
      end
      if (!col[i]) cidx = 2'(i);
    end
    if (zeros == 3'd0)      cls = NONE;
    else if (zeros == 3'd1) cls = HIT;
    else                    cls = GHOST;
  end

  always_comb begin
    state_n    = state;
    col_n      = col;
    match_n    = match;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    code_n     = keyCode;
    valid_n    = 1'b0;
    down_n     = keyDown;
    accept     = 1'b0;
    if (sample) begin
      unique case (state)
        SCAN: begin
          if (cls == HIT) begin
            cand_row_n = ridx;
            cand_col_n = cidx;
            if (DBCOUNT == 1) accept = 1'b1;
            else begin
              match_n = MW'(1);
              state_n = CONFIRM;
            end
          end else begin
            col_n = {col[2:0], col[3]};
          end
        end
        CONFIRM: begin
          if (cls == HIT && ridx == cand_row) begin
            if (match == DB_LAST) accept = 1'b1;
            else                  match_n = match + MW'(1);
          end else begin
            match_n = '0;
            col_n   = {col[2:0], col[3]};
            state_n = SCAN;
          end
        end
        HELD: begin
          // Any hit, even from a different key, keeps the current key held.
          if (cls == HIT) match_n = '0;
          else if (match == DB_LAST) begin
            down_n  = 1'b0;
            match_n = '0;
            col_n   = {col[2:0], col[3]};
            state_n = SCAN;
          end else begin
            match_n = match + MW'(1);
          end
        end
        default: state_n = SCAN;
      endcase
      if (accept) begin
        code_n  = key_code(cand_row_n, cand_col_n);
        valid_n = 1'b1;
        down_n  = 1'b1;
        match_n = '0;
        state_n = HELD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SCAN;
      col      <= COL_RESET;
      cnt      <= '0;
      match    <= '0;
      cand_row <= '0;
      cand_col <= '0;
      keyCode  <= '0;
      keyValid <= 1'b0;
      keyDown  <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      cnt      <= sample ? '0 : cnt + CW'(1);
      match    <= match_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
      keyCode  <= code_n;
      keyValid <= valid_n;
      keyDown  <= down_n;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with DWELL=4, DBCOUNT=3 and a behavioural keypad matrix model.
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row, col, keyCode;
  logic       keyValid, keyDown;
  logic [15:0] pressed = '0;
  int checks = 0, errors = 0, npulse = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;

  typedef struct {
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  exp_col;
    logic        exp_valid;
    logic        exp_down;
    logic [3:0]  exp_code;
  } vec_t;
  vec_t tbl[18];

  keypad_scan #(.CLKSPDMHZ(1), .DWELLUS(4), .DBCOUNT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .keyCode  (keyCode),
    .keyValid (keyValid),
    .keyDown  (keyDown)
  );

  always #5 clk = ~clk;

  // Key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  // Scoreboard: each accepted key event must match the next expected code.
  always @(negedge clk) begin
    if (keyValid === 1'b1) begin
      npulse++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: keyValid with code %0d, none expected", keyCode);
      end else begin
        exp_code = exp_q.pop_front();
        if (keyCode !== exp_code) begin
          errors++;
          $display("FAIL sb_code: got %0d expected %0d", keyCode, exp_code);
        end
      end
    end
  end

  function automatic logic [3:0] col_at(input int k);
    logic [3:0] c;
    c = 4'b1110;
    for (int i = 0; i < (k % 4); i++) c = {c[2:0], c[3]};
    return c;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_down(input logic lvl, input int maxc, output int n);
    n = 0;
    while (keyDown !== lvl && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (keyDown !== lvl) begin
      errors++;
      $display("FAIL wait_keyDown: got %b expected %b within %0d cycles", keyDown, lvl, maxc);
    end
  endtask

  // Returns at the negedge just after col switches to tgt (i.e. right after a sample edge).
  task automatic sync_col(input logic [3:0] tgt);
    logic [3:0] prev;
    int n;
    n = 0;
    prev = col;
    @(negedge clk);
    while (!(col == tgt && prev != tgt) && n < 64) begin
      prev = col;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(col == tgt && prev != tgt)) begin
      errors++;
      $display("FAIL sync_col: got %b expected transition to %b", col, tgt);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 16'h0, 4'b1110, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 16'h0, 4'b1110, 1'b0, 1'b0, 4'd0};
    for (int k = 2; k < 18; k++)
      tbl[k] = '{1'b0, 16'h0, col_at((k - 1) / 4), 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 18; i++) begin
      reset   = tbl[i].rst;
      pressed = tbl[i].keys;
      @(negedge clk);
      chk($sformatf("tbl%0d_col", i), {4'h0, col}, {4'h0, tbl[i].exp_col});
      chk($sformatf("tbl%0d_valid", i), {7'h0, keyValid}, {7'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_down", i), {7'h0, keyDown}, {7'h0, tbl[i].exp_down});
      chk($sformatf("tbl%0d_code", i), {4'h0, keyCode}, {4'h0, tbl[i].exp_code});
    end

    // Clean press of key 9 (row2/col1), aligned to the column switch.
    sync_col(4'b1101);
    exp_q.push_back(4'd9);
    pressed = 16'h0200;
    repeat (11) @(negedge clk);
    chk("press_pre_valid", {7'h0, keyValid}, 8'h0);
    chk("press_pre_down", {7'h0, keyDown}, 8'h0);
    @(negedge clk);
    chk("press_valid", {7'h0, keyValid}, 8'h1);
    chk("press_down", {7'h0, keyDown}, 8'h1);
    chk("press_code", {4'h0, keyCode}, 8'h9);
    @(negedge clk);
    chk("press_pulse_end", {7'h0, keyValid}, 8'h0);
    repeat (7) @(negedge clk);
    chk("held_col", {4'h0, col}, 8'h0D);
    chk("held_down", {7'h0, keyDown}, 8'h1);
    pressed = '0;
    wait_down(1'b0, 40, n);
    chk("release_lat", 8'(n), 8'd12);
    chk("release_col", {4'h0, col}, 8'h0B);

    // Bounce: two hits then a miss during confirm.
    sync_col(4'b1101);
    pressed = 16'h0200;
    repeat (8) @(negedge clk);
    pressed = '0;
    repeat (4) @(negedge clk);
    chk("bounce_col", {4'h0, col}, 8'h0B);
    chk("bounce_down", {7'h0, keyDown}, 8'h0);
    exp_q.push_back(4'd9);
    pressed = 16'h0200;
    wait_down(1'b1, 60, n);
    chk("bounce_stable_code", {4'h0, keyCode}, 8'h9);
    pressed = '0;
    wait_down(1'b0, 40, n);
    chk("bounce_q_empty", 8'(exp_q.size()), 8'd0);

    // Ghost: keys 0 and 4 share col0, two rows low.
    sync_col(4'b1110);
    pressed = 16'h0011;
    repeat (4) @(negedge clk);
    chk("ghost_col1", {4'h0, col}, 8'h0D);
    repeat (16) @(negedge clk);
    chk("ghost_col2", {4'h0, col}, 8'h0D);
    chk("ghost_down", {7'h0, keyDown}, 8'h0);
    pressed = '0;

    // Held key 0 with key 5 pressed on top.
    exp_q.push_back(4'd0);
    pressed = 16'h0001;
    wait_down(1'b1, 60, n);
    chk("held2_code_a", {4'h0, keyCode}, 8'h0);
    pressed = 16'h0021;
    repeat (32) @(negedge clk);
    chk("held2_down", {7'h0, keyDown}, 8'h1);
    chk("held2_col", {4'h0, col}, 8'h0E);
    chk("held2_code_b", {4'h0, keyCode}, 8'h0);
    pressed = '0;
    wait_down(1'b0, 40, n);
    chk("held2_rel_col", {4'h0, col}, 8'h0D);

    // Reset while a key is held.
    exp_q.push_back(4'd9);
    pressed = 16'h0200;
    wait_down(1'b1, 60, n);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_col", {4'h0, col}, 8'h0E);
    chk("rst_mid_down", {7'h0, keyDown}, 8'h0);
    chk("rst_mid_code", {4'h0, keyCode}, 8'h0);
    chk("rst_mid_valid", {7'h0, keyValid}, 8'h0);
    repeat (2) @(negedge clk);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (24) @(negedge clk);
    chk("post_rst_down", {7'h0, keyDown}, 8'h0);
    chk("final_q_empty", 8'(exp_q.size()), 8'd0);
    chk("pulse_count", 8'(npulse), 8'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
